// File: rtl/pipe_scoreboard_pkg.sv
`default_nettype none
// pipe_scoreboard_pkg: constants, result classes and the readiness helper shared by the scoreboard.
// Rev 1.0
package pipe_scoreboard_pkg;

  localparam int FWD_RF = 0;
  localparam int STG_EX = 1;
  localparam int STG_MM = 2;
  localparam int STG_WB = 3;

  typedef enum logic {
    CLS_ALU = 1'b0,
    CLS_LD  = 1'b1
  } res_class_e;

  function automatic logic stage_ready(input int unsigned stage, input int unsigned avail);
    return stage >= avail;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sb_match.sv
`default_nettype none
// pipe_sb_match: priority search of the in-flight entries for one source operand.
// Rev 1.0
module pipe_sb_match
  import pipe_scoreboard_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int DEPTH = 3,
  localparam int RW   = $clog2(NREG),
  localparam int SW   = $clog2(DEPTH + 1),
  localparam int EW   = 1 + RW + SW
) (
  input  logic                en,
  input  logic [RW-1:0]       src,
  input  logic [DEPTH*EW-1:0] entries,
  output logic                hit,
  output logic                ready,
  output logic [SW-1:0]       stage
);

  // Walk from the oldest stage toward stage 1 so the youngest producer is the last writer.
  always_comb begin
    hit   = 1'b0;
    ready = 1'b1;
    stage = '0;
    if (en && (src != '0)) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries[(k-1)*EW + EW-1] && (entries[(k-1)*EW + SW +: RW] == src)) begin
          hit   = 1'b1;
          stage = SW'(k);
          ready = stage_ready(k, 32'(entries[(k-1)*EW +: SW]));
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// pipe_scoreboard: tracks in-flight register writes and produces forwarding selects and the issue stall.
// Rev 1.0
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int NREG        = 32,
  parameter int DEPTH       = 3,
  parameter int ALU_AVAIL   = 1,
  parameter int LD_AVAIL    = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNTW        = 16,
  localparam int RW         = $clog2(NREG),
  localparam int SW         = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rs,
  input  logic [RW-1:0]   issue_rt,
  input  logic            issue_use_rs,
  input  logic            issue_use_rt,
  input  logic [RW-1:0]   issue_rd,
  input  logic            issue_wr,
  input  logic            issue_ld,
  input  logic            flush,
  input  logic            freeze,
  output logic            stall,
  output logic [SW-1:0]   fwd_a,
  output logic [SW-1:0]   fwd_b,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int EW = 1 + RW + SW;
  localparam logic [SW-1:0] c_alu_avail = SW'(ALU_AVAIL);
  localparam logic [SW-1:0] c_ld_avail  = SW'(LD_AVAIL);
  localparam logic [SW-1:0] c_fwd_rf    = SW'(FWD_RF);

  logic            r_v  [STG_EX:DEPTH];
  logic [RW-1:0]   r_rd [STG_EX:DEPTH];
  logic [SW-1:0]   r_av [STG_EX:DEPTH];
  logic [CNTW-1:0] r_cnt;

  logic [DEPTH*EW-1:0] w_entries;
  res_class_e          w_cls;
  logic [SW-1:0]       w_avail;
  logic                w_hit_a, w_rdy_a, w_hit_b, w_rdy_b;
  logic [SW-1:0]       w_stg_a, w_stg_b;
  logic                w_record;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_flat
    assign w_entries[(k-1)*EW +: EW] = {r_v[k], r_rd[k], r_av[k]};
  end

  assign w_cls   = issue_ld ? CLS_LD : CLS_ALU;
  assign w_avail = (w_cls == CLS_LD) ? c_ld_avail : c_alu_avail;

  pipe_sb_match #(.NREG(NREG), .DEPTH(DEPTH)) u_match_a (
    .en      (issue_valid & issue_use_rs),
    .src     (issue_rs),
    .entries (w_entries),
    .hit     (w_hit_a),
    .ready   (w_rdy_a),
    .stage   (w_stg_a)
  );

  pipe_sb_match #(.NREG(NREG), .DEPTH(DEPTH)) u_match_b (
    .en      (issue_valid & issue_use_rt),
    .src     (issue_rt),
    .entries (w_entries),
    .hit     (w_hit_b),
    .ready   (w_rdy_b),
    .stage   (w_stg_b)
  );

  assign stall     = issue_valid & ~(w_rdy_a & w_rdy_b) & ~flush;
  assign fwd_a     = w_hit_a ? w_stg_a : c_fwd_rf;
  assign fwd_b     = w_hit_b ? w_stg_b : c_fwd_rf;
  assign stall_cnt = r_cnt;

  // r0 is never recorded, so it can never appear as a producer.
  assign w_record = issue_valid & issue_wr & ~stall & ~flush & (issue_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = STG_EX; k <= DEPTH; k++) begin
        r_v[k]  <= 1'b0;
        r_rd[k] <= '0;
        r_av[k] <= '0;
      end
      r_cnt <= '0;
    end else if (!freeze) begin
      r_v[STG_EX]  <= w_record;
      r_rd[STG_EX] <= issue_rd;
      r_av[STG_EX] <= w_avail;
      // Younger wrong-path entries landing at or below FLUSH_DEPTH are killed on redirect.
      for (int k = STG_EX + 1; k <= DEPTH; k++) begin
        r_v[k]  <= r_v[k-1] & ~(flush & (k <= FLUSH_DEPTH));
        r_rd[k] <= r_rd[k-1];
        r_av[k] <= r_av[k-1];
      end
      if (stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

endmodule
`default_nettype wire
